fifo_wr_arb: RTL and testbench

- Round-robin write arbiter that shares one single-clock 16x32 FIFO envelope among NUM_REQ requesters.
- Each requester presents bursts using valid/ready/last signalling. The arbiter grants one requester at a time, holds the grant until the burst ends, and drives the FIFO write port.
- Backpressure comes from FIFO full. Two safeguards prevent monopoly or deadlock: a burst-length cap and an idle timeout.
- Sits between the requester blocks and the FIFO envelope's wr_op/wr_data/full inputs.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arb.sv | 121 ++++++++++++
 tb/tb_fifo_wr_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int CNT_W         = 8;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_IDLE_TMO  = 15;

  // Index width for n items, never below 1 so a 1-bit id always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set request at or after i_ptr, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_sel,
  output logic          o_any
);

  int w_idx;

  // Walk from the farthest candidate back toward i_ptr so the nearest hit wins.
  always_comb begin
    o_sel = '0;
    o_any = 1'b0;
    w_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_req[w_idx[IW-1:0]]) begin
        o_sel = w_idx[IW-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter onto one FIFO write port: grant 1 cycle after valid, 1 bubble between grants.
// FIFO full drops the granted ready and holds the grant; burst cap and idle timeout force release.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DAT_WIDTH = 32,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int IDLE_TMO  = DEF_IDLE_TMO,
  parameter int IDW       = clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DAT_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wr_op,
  output logic [DAT_WIDTH-1:0]           fifo_wr_data,
  input  logic                           fifo_full,
  output logic                           grant_vld,
  output logic [IDW-1:0]                 grant_id,
  output logic                           burst_trunc,
  output logic                           tmo_rel
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TMO - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr, r_grant_id;
  logic [CNT_W-1:0]  r_beat_cnt, r_idle_cnt;
  logic              r_burst_trunc, r_tmo_rel;

  logic [IDW-1:0]    w_sel, w_ptr_nxt;
  logic              w_any, w_ready_g, w_beat, w_idle, w_trunc, w_tmo;
  logic [NUM_REQ-1:0] w_ready_vec;
  logic [DAT_WIDTH-1:0] w_req_dat [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_req_dat[g] = req_data[g*DAT_WIDTH +: DAT_WIDTH];
  end

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_sel (w_sel),
    .o_any (w_any)
  );

  assign w_ptr_nxt = (w_sel == IDW'(NUM_REQ - 1)) ? '0 : w_sel + IDW'(1);
  assign w_ready_g = (r_state == XFER) & ~fifo_full;
  assign w_beat    = w_ready_g & req_valid[r_grant_id];
  // Stalled-by-full cycles are neither beats nor idle.
  assign w_idle    = (r_state == XFER) & ~fifo_full & ~req_valid[r_grant_id];

  always_comb begin
    w_ready_vec = '0;
    if (w_ready_g) w_ready_vec[r_grant_id] = 1'b1;
  end

  assign req_ready    = w_ready_vec;
  assign fifo_wr_op   = w_beat;
  assign fifo_wr_data = (r_state == XFER) ? w_req_dat[r_grant_id] : '0;
  assign grant_vld    = (r_state == XFER);
  assign grant_id     = r_grant_id;
  assign burst_trunc  = r_burst_trunc;
  assign tmo_rel      = r_tmo_rel;

  // Release priority: last beat, then burst cap, then idle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_trunc     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = XFER;
      XFER: begin
        if (w_beat && req_last[r_grant_id]) begin
          w_state_nxt = IDLE;
        end else if (w_beat && (r_beat_cnt == BEAT_LAST)) begin
          w_state_nxt = IDLE;
          w_trunc     = 1'b1;
        end else if (w_idle && (r_idle_cnt == IDLE_LAST)) begin
          w_state_nxt = IDLE;
          w_tmo       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_beat_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_burst_trunc <= 1'b0;
      r_tmo_rel     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_burst_trunc <= w_trunc;
      r_tmo_rel     <= w_tmo;
      if (r_state == IDLE) begin
        if (w_any) begin
          r_grant_id <= w_sel;
          r_rr_ptr   <= w_ptr_nxt;
          r_beat_cnt <= '0;
          r_idle_cnt <= '0;
        end
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        r_idle_cnt <= '0;
      end else if (w_idle) begin
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb with a 16x32 FIFO envelope model and per-requester burst sources.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_wr_op;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic              grant_vld;
  logic [IW-1:0]     grant_id;
  logic              burst_trunc, tmo_rel;

  logic [DW-1:0] fmem [DEPTH];
  int            fcnt = 0, fwp = 0, frp = 0;
  logic          rd_op = 1'b1;
  logic          wr_full_err = 1'b0;

  int en [NR];
  int rem [NR];
  int idx [NR];
  int blen [NR];

  logic [31:0] wq[$];
  logic [31:0] rdq[$];
  int          gq[$];
  int          n_bt = 0, n_tmo = 0;
  logic        prev_gv = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  assign fifo_full = (fcnt == DEPTH);

  fifo_wr_arb #(
    .NUM_REQ(NR), .DAT_WIDTH(DW), .MAX_BURST(8), .IDLE_TMO(15), .IDW(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_op(fifo_wr_op), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
    .grant_vld(grant_vld), .grant_id(grant_id),
    .burst_trunc(burst_trunc), .tmo_rel(tmo_rel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int i, input int k);
    return (32'(i + 1) << 28) | 32'(k);
  endfunction

  function automatic logic [31:0] wget(input int k);
    return (k < wq.size()) ? wq[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] rget(input int k);
    return (k < rdq.size()) ? rdq[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic int gget(input int k);
    return (k < gq.size()) ? gq[k] : -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (en[i] != 0) && (rem[i] > 0);
      req_last[i]  = req_valid[i] && (((idx[i] + 1) % blen[i]) == 0);
      req_data[i*DW +: DW] = dat(i, idx[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      en[i] = 0; rem[i] = 0; idx[i] = 0; blen[i] = 1;
    end
    drive_reqs();
    wq.delete(); rdq.delete(); gq.delete();
    n_bt = 0; n_tmo = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_all();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic src(input int i, input int total, input int bl);
    en[i] = 1; rem[i] = total; idx[i] = 0; blen[i] = bl;
  endtask

  // Requester sources, FIFO envelope and event logs; samples at negedge, updates 1ns after posedge.
  initial begin
    logic [NR-1:0] s_acc;
    logic          s_wr, s_full, s_gv;
    logic [DW-1:0] s_wd;
    int            s_cnt;
    forever begin
      @(negedge clk);
      s_acc  = req_valid & req_ready;
      s_wr   = fifo_wr_op;
      s_wd   = fifo_wr_data;
      s_full = fifo_full;
      s_gv   = grant_vld;
      s_cnt  = fcnt;
      assert (!(s_wr && s_full)) else $error("write strobe while FIFO full");
      if (s_wr) wq.push_back(s_wd);
      if (s_gv && !prev_gv) gq.push_back(int'(grant_id));
      prev_gv = s_gv;
      if (burst_trunc) n_bt++;
      if (tmo_rel) n_tmo++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (s_acc[i]) begin
          idx[i]++;
          rem[i]--;
        end
      end
      if (rd_op && s_cnt > 0) begin
        rdq.push_back(fmem[frp]);
        frp = (frp + 1) % DEPTH;
        fcnt--;
      end
      if (s_wr) begin
        if (s_cnt == DEPTH) wr_full_err = 1'b1;
        else begin
          fmem[fwp] = s_wd;
          fwp = (fwp + 1) % DEPTH;
          fcnt++;
        end
      end
      drive_reqs();
    end
  end

  initial begin
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    reset_n = 1'b0;
    clear_all();
    #3;
    chk("rst_grant_vld", grant_vld, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_op", fifo_wr_op, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_trunc", burst_trunc, 0);
    chk("rst_tmo", tmo_rel, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Single 3-beat burst from requester 0.
    src(0, 3, 3); drive_reqs();
    tick();
    chk("t1_gvld", grant_vld, 1);
    chk("t1_gid", grant_id, 0);
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_wr_op", fifo_wr_op, 1);
    chk("t1_wr_data", fifo_wr_data, dat(0, 0));
    repeat (5) tick();
    chk("t1_idle", grant_vld, 0);
    chk("t1_nwr", wq.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("t1_wr%0d", k), wget(k), dat(0, k));
    chk("t1_pulses", n_bt + n_tmo, 0);

    // All four requesters with back-to-back 2-beat bursts.
    do_reset();
    for (int i = 0; i < NR; i++) src(i, 10, 2);
    drive_reqs();
    repeat (15) tick();
    chk("t2_ngrants", gq.size(), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("t2_gnt%0d", k), gget(k), exp_g[k]);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t2_wr%0d", k), wget(k),
          dat(exp_g[k/2], (k/2 == 4) ? 2 + k % 2 : k % 2));

    // 12-beat burst truncated at 8, requester 3 served in between.
    do_reset();
    src(2, 12, 12); src(3, 2, 2); drive_reqs();
    repeat (9) tick();
    chk("t3_trunc_pulse", burst_trunc, 1);
    chk("t3_released", grant_vld, 0);
    repeat (9) tick();
    chk("t3_ngrants", gq.size(), 3);
    chk("t3_gnt0", gget(0), 2);
    chk("t3_gnt1", gget(1), 3);
    chk("t3_gnt2", gget(2), 2);
    chk("t3_ntrunc", n_bt, 1);
    chk("t3_nwr", wq.size(), 14);
    for (int k = 0; k < 14; k++)
      chk($sformatf("t3_wr%0d", k), wget(k),
          (k < 8) ? dat(2, k) : (k < 10) ? dat(3, k - 8) : dat(2, k - 2));

    // Idle timeout: requester 1 stops after 2 beats without last.
    do_reset();
    src(1, 2, 8); src(3, 1, 1); drive_reqs();
    repeat (17) tick();
    chk("t4_held", grant_vld, 1);
    chk("t4_no_tmo_yet", tmo_rel, 0);
    tick();
    chk("t4_tmo_pulse", tmo_rel, 1);
    chk("t4_released", grant_vld, 0);
    tick();
    chk("t4_next_gvld", grant_vld, 1);
    chk("t4_next_gid", grant_id, 3);
    repeat (2) tick();
    chk("t4_ntmo", n_tmo, 1);
    chk("t4_nwr", wq.size(), 3);
    chk("t4_wr2", wget(2), dat(3, 0));

    // FIFO full backpressure: 20 beats into 16 entries with reads stalled.
    do_reset();
    rd_op = 1'b0;
    src(0, 20, 20); drive_reqs();
    repeat (45) tick();
    chk("t5_fcnt", fcnt, 16);
    chk("t5_full", fifo_full, 1);
    chk("t5_ready", req_ready, 0);
    chk("t5_held", grant_vld, 1);
    chk("t5_no_tmo", n_tmo, 0);
    chk("t5_nwr_full", wq.size(), 16);
    rd_op = 1'b1;
    repeat (30) tick();
    chk("t5_nwr", wq.size(), 20);
    chk("t5_nrd", rdq.size(), 20);
    for (int k = 0; k < 20; k++) chk($sformatf("t5_rd%0d", k), rget(k), dat(0, k));
    chk("t5_ntrunc", n_bt, 2);
    chk("t5_done", grant_vld, 0);
    chk("t5_full_err", wr_full_err, 0);

    // Reset asserted mid-burst; pointer restarts at 0.
    do_reset();
    src(2, 5, 5); drive_reqs();
    repeat (2) tick();
    chk("t6_midburst", fifo_wr_op, 1);
    chk("t6_gid_pre", grant_id, 2);
    src(1, 2, 2); drive_reqs();
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_gvld", grant_vld, 0);
    chk("t6_rst_gid", grant_id, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_wr_op", fifo_wr_op, 0);
    chk("t6_rst_wr_data", fifo_wr_data, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_gvld", grant_vld, 1);
    chk("t6_gid", grant_id, 1);
    chk("t6_full_err", wr_full_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
